// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between synchronous-read imem and decode; redirect flushes and squashes.
// Optional combinational response bypass when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus_4,
   input  logic        out_ready
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc    [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [AW+1:0] occupancy;
   logic          empty;
   logic          resp;
   logic          push;
   logic          pop;

   // Reservation counts the in-flight read but never a same-cycle pop.
   assign occupancy = {1'b0, count} + (AW+2)'(inflight);
   assign imem_req  = !rst && !redirect_valid && (occupancy < (AW+2)'(DEPTH));
   assign imem_addr = fetch_pc;
   assign empty     = (count == '0);
   assign resp      = inflight && !redirect_valid;

`ifdef FETCH_BUFFER_BYPASS_EN
   logic bypass;
   assign bypass    = empty && resp && !rst;
   assign out_valid = !empty || bypass;
   assign out_instr = bypass ? imem_rdata  : q_instr[rd_ptr];
   assign out_pc    = bypass ? inflight_pc : q_pc[rd_ptr];
   assign push      = resp && !(bypass && out_ready);
   assign pop       = !empty && out_ready && !redirect_valid;
`else
   assign out_valid = !empty;
   assign out_instr = q_instr[rd_ptr];
   assign out_pc    = q_pc[rd_ptr];
   assign push      = resp;
   assign pop       = out_valid && out_ready && !redirect_valid;
`endif

   assign out_pc_plus_4 = out_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= inflight_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~32'h3;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed timing checks plus randomized ready/redirect/reset traffic.
module tb_fetch_buffer;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BUFFER_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk, rst, redirect_valid, imem_req, out_valid, out_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus_4;

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_pc_plus_4(out_pc_plus_4), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int hs_count = 0;
   int req_count = 0;

   // Reference model: expected delivery order and expected fetch address stream.
   logic [31:0] exp_q [$];
   logic [31:0] exp_tail;
   logic [31:0] exp_fetch;
   int          outstanding;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic flush(input logic [31:0] tgt);
      exp_q.delete();
      exp_tail    = tgt & ~32'h3;
      exp_fetch   = exp_tail;
      outstanding = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + 32'd4;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
   endtask

   task automatic samp;
      @(negedge clk);
      #1;
   endtask

   // Synchronous-read memory: data for a request appears during the following cycle.
   initial begin : memory
      logic        req_s;
      logic [31:0] addr_s;
      forever begin
         @(negedge clk);
         req_s  = imem_req;
         addr_s = imem_addr;
         @(posedge clk);
         #1;
         imem_rdata = req_s ? mem_word(addr_s) : 32'hDEAD_BEEF;
      end
   end

   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && !redirect_valid) begin
            if (imem_req) begin
               check("imem_addr", imem_addr, exp_fetch);
               exp_fetch = exp_fetch + 32'd4;
               outstanding++;
               req_count++;
            end
            if (out_valid && out_ready) begin
               hs_count++;
               outstanding--;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL out_pc actual=%h required=<none expected>", out_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("out_pc", out_pc, e);
                  check("out_pc_plus_4", out_pc_plus_4, e + 32'd4);
                  check("out_instr", out_instr, mem_word(e));
               end
            end
            check("occupancy_bound", 32'(outstanding <= DEPTH), 32'd1);
         end
      end
   end

   initial begin : stimulus
      int fv;
      int h0;
      int r0;
      int r;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b1;
      imem_rdata = '0;
      flush(RESET_PC);
      repeat (3) tick;
      samp;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);

      // Reset release: cycle 0 begins here.
      tick;
      rst = 1'b0;
      samp;
      check("c0_req", 32'(imem_req), 32'd1);
      check("c0_addr", imem_addr, RESET_PC);
      fv = out_valid ? 0 : -1;
      for (int c = 1; c < 10; c++) begin
         tick;
         samp;
         if (out_valid && fv < 0) fv = c;
      end
      check("first_valid_cycle", 32'(fv), 32'(LAT));
      h0 = hs_count;
      repeat (10) begin
         tick;
         samp;
      end
      check("throughput", 32'(hs_count - h0), 32'd10);

      // Reset with redirect asserted together: reset wins.
      tick;
      rst = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0500;
      flush(RESET_PC);
      tick;
      rst = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      samp;
      check("rr_valid", 32'(out_valid), 32'd0);
      check("rr_req", 32'(imem_req), 32'd1);
      check("rr_addr", imem_addr, RESET_PC);
      r0 = req_count - 1;
      repeat (9) begin
         tick;
         samp;
      end
      check("bp_reqs", 32'(req_count - r0), 32'(DEPTH));
      check("bp_req_low", 32'(imem_req), 32'd0);
      tick;
      out_ready = 1'b1;
      samp;
      check("pop_valid", 32'(out_valid), 32'd1);
      check("pop_cycle_req", 32'(imem_req), 32'd0);
      tick;
      out_ready = 1'b0;
      samp;
      check("pop_next_req", 32'(imem_req), 32'd1);
      tick;
      out_ready = 1'b1;
      repeat (10) tick;

      // Fill from 0x20 under backpressure, then redirect with one read in flight.
      tick;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0020;
      out_ready = 1'b0;
      flush(32'h0000_0020);
      tick;
      redirect_valid = 1'b0;
      repeat (2) tick;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0102;
      out_ready = 1'b1;
      flush(32'h0000_0102);
      samp;
      check("rd0_req", 32'(imem_req), 32'd0);
      for (int c = 1; c <= 3; c++) begin
         tick;
         redirect_valid = 1'b0;
         samp;
         if (c == 1) begin
            check("rd1_req", 32'(imem_req), 32'd1);
            check("rd1_addr", imem_addr, 32'h0000_0100);
         end
         if (c <= LAT) check("rd_valid_low", 32'(out_valid), 32'd0);
         else if (c == LAT + 1) begin
            check("rd_valid_high", 32'(out_valid), 32'd1);
            check("rd_pc", out_pc, 32'h0000_0100);
         end
      end

      // Back-to-back redirects, the last targets the address-space wrap.
      tick;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      flush(32'h0000_0200);
      tick;
      redirect_pc = 32'hFFFF_FFF8;
      flush(32'hFFFF_FFF8);
      tick;
      redirect_valid = 1'b0;
      samp;
      check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
      tick;
      samp;
      check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
      tick;
      samp;
      check("wrap_addr2", imem_addr, 32'h0000_0000);
      repeat (8) tick;

      repeat (3000) begin
         tick;
         out_ready = ($urandom_range(0, 9) < 7);
         rst = 1'b0;
         redirect_valid = 1'b0;
         r = $urandom_range(0, 199);
         if (r < 2) begin
            rst = 1'b1;
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc = $urandom;
            flush(RESET_PC);
         end else if (r < 10) begin
            redirect_valid = 1'b1;
            redirect_pc = (r == 9) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            flush(redirect_pc);
         end
      end
      tick;
      rst = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick;
      samp;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
